// File: rtl/dff_scoreboard.sv
// dff_scoreboard: on-the-fly checker for a D flip-flop with asynchronous active-low reset
// and synchronous active-low clear. It keeps a one-bit reference model of the observed
// flip-flop and compares it with the observed Q on every rising clock edge while armed.
//
// Optional feature macro: DFF_SCOREBOARD_FIRST_FAIL_EN adds the first_fail output.
//
// Parameters:
//   CNT_W   - width of chk_count / err_count (and first_fail)
//   MAX_ERR - mismatch count at which the checker latches into FAIL (1 .. 2^CNT_W-1)
//
// Ports:
//   clk         - clock shared with the observed flip-flop (rising edge)
//   reset       - asynchronous active-high reset of the checker
//   check_en    - level enable for checking
//   dut_d       - observed D
//   dut_reset_n - observed asynchronous reset, active low
//   dut_clear_n - observed synchronous clear, active low
//   dut_q       - observed Q
//   mismatch    - one-cycle pulse after a failed compare
//   error       - sticky, high while in FAIL
//   chk_count   - compares performed (saturating)
//   err_count   - failed compares (saturating)
//   exp_q       - current reference-model value
//   first_fail  - chk_count index of the first failed compare (macro only)
module dff_scoreboard #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_ERR = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             check_en,
  input  logic             dut_d,
  input  logic             dut_reset_n,
  input  logic             dut_clear_n,
  input  logic             dut_q,
  output logic             mismatch,
  output logic             error,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             exp_q
`ifdef DFF_SCOREBOARD_FIRST_FAIL_EN
  ,
  output logic [CNT_W-1:0] first_fail
`endif
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] MaxErr = CNT_W'(MAX_ERR);

  typedef enum logic [1:0] {StIdle, StArm, StCheck, StFail} state_e;

  state_e           state_q, state_d;
  logic             model_q, model_d;
  logic             mismatch_q;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             exp_now;
  logic             do_cmp;
  logic             miss;

  always_comb begin
    model_d = dut_reset_n & dut_clear_n & dut_d;
    // The async reset of the observed flop clears Q before the edge, overriding exp_q.
    exp_now = dut_reset_n ? model_q : 1'b0;
    do_cmp  = (state_q == StCheck);
    miss    = do_cmp && (dut_q != exp_now);

    chk_d = chk_q;
    if (do_cmp && (chk_q != CntMax)) chk_d = chk_q + CntOne;
    err_d = err_q;
    if (miss && (err_q != CntMax)) err_d = err_q + CntOne;

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (check_en) state_d = StArm;
      StArm:   state_d = check_en ? StCheck : StIdle;
      StCheck: begin
        // Reaching the threshold wins over a simultaneous drop of check_en.
        if (miss && (err_d >= MaxErr)) state_d = StFail;
        else if (!check_en)            state_d = StIdle;
      end
      StFail:  state_d = StFail;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      model_q    <= 1'b0;
      mismatch_q <= 1'b0;
      chk_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      model_q    <= model_d;
      mismatch_q <= miss;
      chk_q      <= chk_d;
      err_q      <= err_d;
    end
  end

`ifdef DFF_SCOREBOARD_FIRST_FAIL_EN
  logic [CNT_W-1:0] first_fail_q;

  // err_q is zero only before the first miss since reset, so it marks the first failure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_fail_q <= '0;
    end else if (miss && (err_q == '0)) begin
      first_fail_q <= chk_q;
    end
  end

  assign first_fail = first_fail_q;
`endif

  assign mismatch  = mismatch_q;
  assign error     = (state_q == StFail);
  assign chk_count = chk_q;
  assign err_count = err_q;
  assign exp_q     = model_q;

endmodule

// File: tb/tb_dff_scoreboard.sv
// Self-checking bench for dff_scoreboard (CNT_W=4, MAX_ERR=3). A behavioural flip-flop
// provides dut_q; fault_en overrides it to inject wrong Q values. Expected results are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_dff_scoreboard;

  localparam int unsigned CntW   = 4;
  localparam int unsigned MaxErr = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            check_en;
  logic            dut_d;
  logic            dut_reset_n;
  logic            dut_clear_n;
  logic            dut_q;
  logic            mismatch;
  logic            error;
  logic [CntW-1:0] chk_count;
  logic [CntW-1:0] err_count;
  logic            exp_q;
`ifdef DFF_SCOREBOARD_FIRST_FAIL_EN
  logic [CntW-1:0] first_fail;
`endif

  logic ff_q;
  logic fault_en;
  logic fault_val;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string name;
    int    chk;
    int    err;
    int    errf;
    int    expq;
  } st_t;

  typedef struct {
    int chk;
    int err;
    int errf;
  } mm_t;

  st_t sq[$];
  mm_t mq[$];

  // {d, reset_n, clear_n} for the clean run
  logic [2:0] vec [14] = '{3'b011, 3'b011, 3'b001, 3'b111, 3'b111, 3'b110, 3'b111,
                           3'b011, 3'b011, 3'b100, 3'b111, 3'b111, 3'b011, 3'b111};

  always #5 clk = ~clk;

  // Correct flip-flop under observation
  always_ff @(posedge clk or negedge dut_reset_n) begin
    if (!dut_reset_n)      ff_q <= 1'b0;
    else if (!dut_clear_n) ff_q <= 1'b0;
    else                   ff_q <= dut_d;
  end

  assign dut_q = fault_en ? fault_val : ff_q;

  dff_scoreboard #(
    .CNT_W  (CntW),
    .MAX_ERR(MaxErr)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .check_en   (check_en),
    .dut_d      (dut_d),
    .dut_reset_n(dut_reset_n),
    .dut_clear_n(dut_clear_n),
    .dut_q      (dut_q),
    .mismatch   (mismatch),
    .error      (error),
    .chk_count  (chk_count),
    .err_count  (err_count),
    .exp_q      (exp_q)
`ifdef DFF_SCOREBOARD_FIRST_FAIL_EN
    ,
    .first_fail (first_fail)
`endif
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d, input logic rn, input logic cn);
    dut_d       = d;
    dut_reset_n = rn;
    dut_clear_n = cn;
  endtask

  task automatic push_st(input string name, input int chk, input int err, input int errf,
                         input int expq);
    st_t r;
    r.name = name; r.chk = chk; r.err = err; r.errf = errf; r.expq = expq;
    sq.push_back(r);
  endtask

  task automatic push_mm(input int chk, input int err, input int errf);
    mm_t r;
    r.chk = chk; r.err = err; r.errf = errf;
    mq.push_back(r);
  endtask

  // Assert the checker reset between edges; outputs must clear without a clock edge.
  task automatic sb_reset(input string name);
    reset    = 1'b1;
    check_en = 1'b0;
    #1;
    cmp({name, "_chk0"}, 32'(chk_count), 0);
    cmp({name, "_err0"}, 32'(err_count), 0);
    cmp({name, "_error0"}, 32'(error), 0);
    cmp({name, "_mismatch0"}, 32'(mismatch), 0);
    cmp({name, "_expq0"}, 32'(exp_q), 0);
`ifdef DFF_SCOREBOARD_FIRST_FAIL_EN
    cmp({name, "_ff0"}, 32'(first_fail), 0);
`endif
    step(1);
    reset = 1'b0;
  endtask

  // Monitor: checks every mismatch pulse and any queued state snapshot.
  always @(negedge clk) begin
    if (mismatch === 1'b1) begin
      if (mq.size() == 0) begin
        cmp("spurious_mismatch", 32'(mismatch), 0);
      end else begin
        mm_t m;
        m = mq.pop_front();
        cmp("mm_err_count", 32'(err_count), 32'(m.err));
        cmp("mm_chk_count", 32'(chk_count), 32'(m.chk));
        cmp("mm_error", 32'(error), 32'(m.errf));
      end
    end
    while (sq.size() > 0) begin
      st_t s;
      s = sq.pop_front();
      cmp({s.name, "_chk"}, 32'(chk_count), 32'(s.chk));
      cmp({s.name, "_err"}, 32'(err_count), 32'(s.err));
      cmp({s.name, "_error"}, 32'(error), 32'(s.errf));
      cmp({s.name, "_expq"}, 32'(exp_q), 32'(s.expq));
    end
  end

  initial begin
    reset     = 1'b1;
    check_en  = 1'b0;
    fault_en  = 1'b0;
    fault_val = 1'b0;
    drive(1'b0, 1'b1, 1'b1);
    step(2);
    cmp("por_chk", 32'(chk_count), 0);
    cmp("por_err", 32'(err_count), 0);
    cmp("por_error", 32'(error), 0);
    cmp("por_expq", 32'(exp_q), 0);
    reset = 1'b0;
    step(1);
    push_st("idle", 0, 0, 0, 0);

    // Clean run: 12 compares, check_en dropped on the last compare edge.
    check_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vec[i][2], vec[i][1], vec[i][0]);
      if (i == 13) check_en = 1'b0;
      step(1);
      push_st("clean", (i >= 2) ? i - 1 : 0, 0, 0, int'(vec[i][2] & vec[i][1] & vec[i][0]));
    end
    step(3);
    push_st("clean_hold", 12, 0, 0, 1);
    step(1);
    sb_reset("rst_idle");

    // Reset versus clear priority, then a second fault, then checker reset mid-CHECK.
    check_en = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    step(2);
    push_st("prio_arm", 0, 0, 0, 1);
    drive(1'b1, 1'b0, 1'b0);
    step(1);
    push_st("prio_pass", 1, 0, 0, 0);
    fault_en  = 1'b1;
    fault_val = 1'b1;
    push_mm(2, 1, 0);
    step(1);
    push_st("prio_fail", 2, 1, 0, 0);
    fault_en = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    step(1);
    push_st("prio_release", 3, 1, 0, 1);
    step(1);
    push_st("d1_pass", 4, 1, 0, 1);
    fault_en  = 1'b1;
    fault_val = 1'b0;
    push_mm(5, 2, 0);
    step(1);
    fault_en = 1'b0;
    step(1);
    push_st("err2", 6, 2, 0, 1);
    step(1);
    sb_reset("rst_mid");
    step(3);
    push_st("post_rst_idle", 0, 0, 0, 1);

    // Stuck-at-1 with D=0; also re-checks enable latency from IDLE.
    drive(1'b0, 1'b1, 1'b1);
    check_en = 1'b1;
    step(2);
    push_st("lat_arm", 0, 0, 0, 0);
    step(1);
    push_st("lat_first", 1, 0, 0, 0);
    fault_en  = 1'b1;
    fault_val = 1'b1;
    push_mm(2, 1, 0);
    push_mm(3, 2, 0);
    push_mm(4, 3, 1);
    step(3);
    push_st("stuck_fail", 4, 3, 1, 0);
    step(5);
    push_st("stuck_frozen", 4, 3, 1, 0);
`ifdef DFF_SCOREBOARD_FIRST_FAIL_EN
    cmp("first_fail", 32'(first_fail), 1);
`endif
    fault_en = 1'b0;
    step(1);
    sb_reset("rst_fail");

    // Saturation: 20 clean compares, then one fault at the saturated count.
    check_en = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    step(22);
    push_st("sat_clean", 15, 0, 0, 1);
    fault_en  = 1'b1;
    fault_val = 1'b0;
    push_mm(15, 1, 0);
    step(1);
    fault_en = 1'b0;
    step(1);
    push_st("sat_fault", 15, 1, 0, 1);

    @(negedge clk);
    #1;
    cmp("mm_queue_empty", 32'(mq.size()), 0);
    cmp("st_queue_empty", 32'(sq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_scoreboard.md
# dff_scoreboard

- Synthesizable on-the-fly checker for a D flip-flop with asynchronous active-low reset (`reset_n`) and synchronous active-low clear (`clear_n`).
- Observes the same pins the bench drives into the flip-flop: `D`, `reset_n`, `clear_n`, plus the flip-flop output `Q`.
- Keeps a one-bit reference model of the flip-flop and compares it against `Q` every clock.
- Reports mismatch pulses, counts and a sticky error; benches and FPGA bring-up use it in place of waveform inspection.

## Interface
- `CNT_W`, 16: width of the check and mismatch counters.
- `MAX_ERR`, 1: mismatch count at which the FSM enters FAIL (1 ≤ MAX_ERR ≤ 2^CNT_W−1).

Ports, with clock and reset first:
- `clk` in 1: single clock, shared with the observed flip-flop; all sampling is on the rising edge.
- `reset` in 1: asynchronous, active-high reset of the scoreboard itself.
- `check_en` in 1: level-sensitive enable for checking.
- `dut_d` in 1: observed D.
- `dut_reset_n` in 1: observed asynchronous reset, active low.
- `dut_clear_n` in 1: observed synchronous clear, active low.
- `dut_q` in 1: observed Q.
- `mismatch` out 1: one-cycle pulse on a failed compare.
- `error` out 1: sticky; high while in FAIL.
- `chk_count` out CNT_W: number of compares performed.
- `err_count` out CNT_W: number of failed compares.
- `exp_q` out 1: current reference-model value.
- `first_fail` out CNT_W: `chk_count` value at the first mismatch. Present only with the macro.

## Operation
- **Reference model.** Register `exp_q` updates on each rising edge:
  - 0 if `dut_reset_n`=0;
  - else 0 if `dut_clear_n`=0;
  - else `dut_d`.
- **Expected value at a compare.** `exp_now` = 0 if the sampled `dut_reset_n`=0, else `exp_q`. This models the asynchronous reset overriding the previous edge.
- **FSM states:** IDLE, ARM, CHECK, FAIL.
  - IDLE: no compares; `exp_q` still tracks the model. Goes to ARM when `check_en`=1.
  - ARM: one cycle so that `exp_q` holds a valid value. Goes to CHECK if `check_en`=1, else IDLE.
  - CHECK: each edge compares the sampled `dut_q` with `exp_now`.
    - Every compare increments `chk_count`.
    - On inequality: pulse `mismatch` and increment `err_count`.
    - When `err_count` reaches MAX_ERR, go to FAIL.
    - If `check_en`=0, go to IDLE. Counters hold their values.
  - FAIL: `error`=1. No further compares; counters frozen. Only `reset` exits this state.
- **Counters.** Both saturate at 2^CNT_W−1 and never wrap. A saturated `chk_count` keeps checking.
- **Simultaneous conditions.**
  - `dut_reset_n`=0 and `dut_clear_n`=0 together: expected 0, reset wins.
  - A mismatch on the same edge as `check_en` falling is still counted, and the FSM goes to FAIL if the threshold is met. FAIL has priority over IDLE.
- **`reset` asserted at any time**, including mid-CHECK:
  - Immediately forces IDLE.
  - All outputs go to 0: `exp_q`, `mismatch`, `error`, both counters, `first_fail`.

## Timing
- **Compare latency.** The `dut_*` inputs sampled at edge k determine `exp_q` after edge k. The `dut_q` sampled at edge k+1 is compared against it.
- **Output timing.** `mismatch` and the `err_count` increment are registered and become visible after edge k+1. One compare is performed per cycle.
- **Enable to first compare.** `check_en` rising before edge n gives IDLE→ARM at n, ARM→CHECK at n+1, and the first compare at n+2.
- **`error`** rises in the same cycle as the `mismatch` pulse that reaches MAX_ERR.
- **`reset` deassertion** is synchronous to `clk` at the system level. The first state change can occur at the edge following release.

## Configuration
- Macro: `DFF_SCOREBOARD_FIRST_FAIL_EN`.
- **Defined:**
  - Port `first_fail` exists.
  - It captures `chk_count` (the pre-increment value, i.e. the 0-based index of the failing compare) on the first mismatch after `reset`.
  - It holds that value until the next `reset`.
- **Undefined:** the port and its register are absent, and all other behaviour is identical.

## Test plan
- **Clean run.** Drive the standard stimulus: reset pulse, D=1, clear pulse, D=0, reset overlapping clear, D=1, with `check_en`=1 for 12 compares against a correct flip-flop → `mismatch` never pulses, `err_count`=0, `chk_count`=12, `error`=0.
- **Stuck-at fault.** Force `dut_q`=1 while D=0 for 3 compares with MAX_ERR=3 → three `mismatch` pulses, `err_count`=3, `error`=1 on the third pulse. With the macro defined, `first_fail` equals the index of the first bad compare. Then 5 more cycles → all counters unchanged.
- **Reset versus clear priority.** Assert `dut_reset_n`=0 and `dut_clear_n`=0 together while D=1 → `exp_q`=0. A flip-flop showing Q=0 passes; Q=1 gives `err_count`+1.
- **Enable latency.** Raise `check_en` before edge 10 → `chk_count` first increments after edge 12. Drop `check_en` → FSM returns to IDLE and counters hold.
- **Scoreboard reset mid-CHECK.** Assert `reset` between edges with `err_count`=2 → all outputs 0 immediately without a clock edge. After release, the FSM sits in IDLE.
- **Saturation.** With CNT_W=4, run 20 clean compares → `chk_count` stays at 15 and checking continues. Inject one fault → `err_count`=1.
